// File: rtl/axi_lite_slave_regs.sv
// AXI-Lite register bank responder: NUM_REGS x 32-bit read/write registers,
// independent write and read channels, SLVERR on out-of-range addresses.
//
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   AW*/W*/B*                  - AXI-Lite write address, data, response channels
//   AR*/R*                     - AXI-Lite read address, data channels
//   reg_q                      - flat register contents, reg i at [32*i+31:32*i]
//   reg_wr_stb                 - one-cycle pulse per register on a committed write
module axi_lite_slave_regs #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          NUM_REGS  = 16,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              AWADDR,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [31:0]              WDATA,
    input  logic                     WVALID,
    output logic                     WREADY,
    output logic                     BVALID,
    input  logic                     BREADY,
    output logic [1:0]               BRESP,
    input  logic [31:0]              ARADDR,
    input  logic                     ARVALID,
    output logic                     ARREADY,
    output logic [31:0]              RDATA,
    output logic                     RVALID,
    input  logic                     RREADY,
    output logic [1:0]               RRESP,
    output logic [NUM_REGS*32-1:0]   reg_q,
    output logic [NUM_REGS-1:0]      reg_wr_stb
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    // Word index relative to BASE_ADDR; byte-lane bits drop out in the shift.
    function automatic logic [31:0] addr_idx(input logic [31:0] addr);
        return (addr - BASE_ADDR) >> 2;
    endfunction

    function automatic logic addr_ok(input logic [31:0] addr);
        return (addr >= BASE_ADDR) && (addr_idx(addr) < 32'(NUM_REGS));
    endfunction

    logic [31:0] regs [NUM_REGS];

    // ---------------- write path ----------------
    w_state_t    w_state, w_next;
    logic        aw_held, w_held;
    logic [31:0] aw_addr_q, w_data_q;
    logic        aw_hs, w_hs, w_commit;
    logic [31:0] wr_addr, wr_data, wr_idx;
    logic        wr_ok;

    assign aw_hs   = AWVALID && AWREADY;
    assign w_hs    = WVALID && WREADY;
    // A beat completing this cycle is used directly; otherwise the held copy.
    assign wr_addr = aw_held ? aw_addr_q : AWADDR;
    assign wr_data = w_held ? w_data_q : WDATA;
    assign wr_idx  = addr_idx(wr_addr);
    assign wr_ok   = addr_ok(wr_addr);

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_next;
        end
    end

    always_comb begin
        w_next   = w_state;
        AWREADY  = 1'b0;
        WREADY   = 1'b0;
        w_commit = 1'b0;
        case (w_state)
            W_IDLE: begin
                AWREADY = !reset && !aw_held;
                WREADY  = !reset && !w_held;
                if ((aw_held || (AWVALID && AWREADY)) &&
                    (w_held || (WVALID && WREADY))) begin
                    w_commit = 1'b1;
                    w_next   = W_RESP;
                end
            end
            W_RESP: begin
                if (BVALID && BREADY) begin
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            BVALID    <= 1'b0;
            BRESP     <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_addr_q <= AWADDR;
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= WDATA;
            end
            if (w_commit) begin
                BVALID <= 1'b1;
                BRESP  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (BVALID && BREADY) begin
                BVALID  <= 1'b0;
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
            reg_wr_stb <= '0;
        end else begin
            reg_wr_stb <= '0;
            if (w_commit && wr_ok) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (wr_idx == 32'(i)) begin
                        regs[i]       <= wr_data;
                        reg_wr_stb[i] <= 1'b1;
                    end
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
        assign reg_q[32*gi +: 32] = regs[gi];
    end

    // ---------------- read path ----------------
    r_state_t    r_state, r_next;
    logic        ar_hs, rd_ok;
    logic [31:0] rd_idx, rd_word;

    assign ar_hs  = ARVALID && ARREADY;
    assign rd_idx = addr_idx(ARADDR);
    assign rd_ok  = addr_ok(ARADDR);

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == 32'(i)) begin
                rd_word = regs[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    always_comb begin
        r_next  = r_state;
        ARREADY = 1'b0;
        case (r_state)
            R_IDLE: begin
                ARREADY = !reset;
                if (ARVALID && ARREADY) begin
                    r_next = R_DATA;
                end
            end
            R_DATA: begin
                if (RVALID && RREADY) begin
                    r_next = R_IDLE;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Sampling regs before the write edge lands gives read-before-write
    // ordering when both channels hit the same register together.
    always_ff @(posedge clk) begin
        if (reset) begin
            RVALID <= 1'b0;
            RDATA  <= '0;
            RRESP  <= RESP_OKAY;
        end else if (ar_hs) begin
            RVALID <= 1'b1;
            RDATA  <= rd_ok ? rd_word : 32'h0;
            RRESP  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (RVALID && RREADY) begin
            RVALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Directed self-checking bench for axi_lite_slave_regs (16 registers at 0x0).
// Ports: none; drives all DUT inputs and checks outputs after each edge.
module tb_axi_lite_slave_regs;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  AWADDR, WDATA, ARADDR, RDATA;
    logic         AWVALID, AWREADY, WVALID, WREADY;
    logic         BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;
    logic [1:0]   BRESP, RRESP;
    logic [511:0] reg_q;
    logic [15:0]  reg_wr_stb;

    logic [31:0]  model [16];
    int           tests = 0;
    int           fails = 0;
    logic [31:0]  rd;

    always #5 clk = ~clk;

    axi_lite_slave_regs #(
        .BASE_ADDR(32'h0),
        .NUM_REGS (16),
        .RESET_VAL(32'h0)
    ) dut (
        .clk(clk), .reset(reset),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY), .RRESP(RRESP),
        .reg_q(reg_q), .reg_wr_stb(reg_wr_stb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] model_flat();
        logic [511:0] f;
        for (int i = 0; i < 16; i++) f[32*i +: 32] = model[i];
        return f;
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        AWADDR = a; AWVALID = 1'b1; WDATA = d; WVALID = 1'b1; BREADY = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        tick();
        if (a < 32'h40) model[a[5:2]] = d;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d);
        ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1;
        tick();
        d = RDATA;
        ARVALID = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WVALID = 1'b0;
        BREADY = 1'b0; ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 32'h0;

        // ---- reset ----
        tick();
        tick();
        chk("rst_awready", AWREADY, 1'b0);
        chk("rst_arready", ARREADY, 1'b0);
        chk("rst_bvalid", BVALID, 1'b0);
        chk("rst_rvalid", RVALID, 1'b0);
        chk("rst_regq", reg_q, model_flat());
        reset = 1'b0;
        #1;
        chk("post_rst_awready", AWREADY, 1'b1);
        chk("post_rst_wready", WREADY, 1'b1);

        // ---- 1: simultaneous AW/W ----
        tick();
        AWADDR = 32'h08; AWVALID = 1'b1;
        WDATA = 32'hDEADBEEF; WVALID = 1'b1; BREADY = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        chk("t1_bvalid", BVALID, 1'b1);
        chk("t1_bresp", BRESP, 2'b00);
        chk("t1_reg2", reg_q[95:64], 32'hDEADBEEF);
        chk("t1_stb", reg_wr_stb, 16'h0004);
        tick();
        model[2] = 32'hDEADBEEF;
        chk("t1_bvalid_clr", BVALID, 1'b0);
        chk("t1_stb_clr", reg_wr_stb, 16'h0000);
        ARADDR = 32'h08; ARVALID = 1'b1; RREADY = 1'b0;
        tick();
        ARVALID = 1'b0;
        chk("t1_rvalid", RVALID, 1'b1);
        chk("t1_rdata", RDATA, 32'hDEADBEEF);
        chk("t1_rresp", RRESP, 2'b00);
        RREADY = 1'b1;
        tick();
        chk("t1_rvalid_clr", RVALID, 1'b0);

        // ---- 2: W early, AW late, slow BREADY ----
        BREADY = 1'b0;
        WDATA = 32'h12345678; WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        chk("t2_wready_held", WREADY, 1'b0);
        chk("t2_awready_open", AWREADY, 1'b1);
        tick();
        tick();
        chk("t2_no_early_b", BVALID, 1'b0);
        chk("t2_no_early_wr", reg_q[511:480], 32'h0);
        AWADDR = 32'h3C; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        model[15] = 32'h12345678;
        chk("t2_bvalid", BVALID, 1'b1);
        chk("t2_reg15", reg_q[511:480], 32'h12345678);
        chk("t2_stb", reg_wr_stb, 16'h8000);
        for (int c = 0; c < 5; c++) begin
            chk("t2_bvalid_hold", BVALID, 1'b1);
            chk("t2_bresp_hold", BRESP, 2'b00);
            chk("t2_awready_low", AWREADY, 1'b0);
            chk("t2_wready_low", WREADY, 1'b0);
            tick();
        end
        BREADY = 1'b1;
        tick();
        chk("t2_bvalid_clr", BVALID, 1'b0);

        // ---- 3: out-of-range ----
        AWADDR = 32'h40; AWVALID = 1'b1;
        WDATA = 32'hFFFFFFFF; WVALID = 1'b1; BREADY = 1'b0;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        chk("t3_bvalid", BVALID, 1'b1);
        chk("t3_bresp", BRESP, 2'b10);
        chk("t3_stb", reg_wr_stb, 16'h0000);
        chk("t3_regq", reg_q, model_flat());
        BREADY = 1'b1;
        tick();
        do_read(32'h40, rd);
        chk("t3_rdata", rd, 32'h0);
        chk("t3_rresp", RRESP, 2'b10);

        // ---- 4: same-edge read and write ----
        do_write(32'h0C, 32'h11);
        AWADDR = 32'h0C; AWVALID = 1'b1; WDATA = 32'h55; WVALID = 1'b1;
        ARADDR = 32'h0C; ARVALID = 1'b1; BREADY = 1'b1; RREADY = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        model[3] = 32'h55;
        chk("t4_rdata_old", RDATA, 32'h11);
        chk("t4_reg3_new", reg_q[127:96], 32'h55);
        tick();
        do_read(32'h0C, rd);
        chk("t4_rdata_new", rd, 32'h55);

        // ---- 5: read with stalled RREADY ----
        do_write(32'h00, 32'hA5A5_0F0F);
        ARADDR = 32'h00; ARVALID = 1'b1; RREADY = 1'b0;
        tick();
        ARVALID = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("t5_rvalid_hold", RVALID, 1'b1);
            chk("t5_rdata_hold", RDATA, 32'hA5A5_0F0F);
            chk("t5_arready_low", ARREADY, 1'b0);
            tick();
        end
        RREADY = 1'b1;
        tick();
        chk("t5_rvalid_clr", RVALID, 1'b0);
        chk("t5_arready_back", ARREADY, 1'b1);

        // ---- 6: reset with both responses pending ----
        AWADDR = 32'h04; AWVALID = 1'b1; WDATA = 32'h77; WVALID = 1'b1;
        ARADDR = 32'h04; ARVALID = 1'b1; BREADY = 1'b0; RREADY = 1'b0;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        chk("t6_bvalid_pre", BVALID, 1'b1);
        chk("t6_rvalid_pre", RVALID, 1'b1);
        reset = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        chk("t6_bvalid", BVALID, 1'b0);
        chk("t6_rvalid", RVALID, 1'b0);
        chk("t6_regq", reg_q, model_flat());
        chk("t6_stb", reg_wr_stb, 16'h0000);
        chk("t6_awready_rst", AWREADY, 1'b0);
        chk("t6_wready_rst", WREADY, 1'b0);
        chk("t6_arready_rst", ARREADY, 1'b0);
        reset = 1'b0;
        #1;
        chk("t6_awready", AWREADY, 1'b1);
        chk("t6_wready", WREADY, 1'b1);
        chk("t6_arready", ARREADY, 1'b1);
        tick();
        chk("t6_no_resp", BVALID, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
